// File: rtl/output_hold_pkg.sv
// Shared types for the output dwell-enforcement block.
package output_hold_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } chan_state_e;

endpackage

// File: rtl/output_hold_chan.sv
// One output channel: holds each level for at least 2**NHold cycles and
// replays any request seen during the dwell as one minimum-width level.
module output_hold_chan
   import output_hold_pkg::*;
#(
   parameter int unsigned NHold = 21,
   parameter logic        INIT  = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic req,
   output logic out_sig,
   output logic busy,
   output logic idle_nxt_c
);

   chan_state_e      state_q, state_d;
   logic [NHold-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             out_q, out_d;
   logic             diff;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         out_q   <= INIT;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      out_d   = out_q;
      diff    = (req != out_q);
      case (state_q)
         ST_IDLE: begin
            if (diff) begin
               out_d   = req;
               cnt_d   = '0;
               pend_d  = 1'b0;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (cnt_q != '1) begin
               cnt_d = cnt_q + NHold'(1);
               // Sticky: a request that later reverts still earns one toggle.
               if (diff) pend_d = 1'b1;
            end else if (pend_q | diff) begin
               out_d  = ~out_q;
               cnt_d  = '0;
               pend_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
      idle_nxt_c = (state_d == ST_IDLE) & ~pend_d;
   end

   assign out_sig = out_q;
   assign busy    = (state_q == ST_HOLD);

endmodule

// File: rtl/output_hold.sv
// Multi-channel output dwell enforcer: independent per-bit channels plus a
// registered all-channels-idle flag.
module output_hold
   import output_hold_pkg::*;
#(
   parameter int unsigned NCH   = 4,
   parameter int unsigned NHold = 21,
   parameter logic        INIT  = 1'b0
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic [NCH-1:0] req_in,
   output logic [NCH-1:0] out_sig,
   output logic [NCH-1:0] busy,
   output logic           all_idle
);

   logic [NCH-1:0] idle_nxt_c;

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      output_hold_chan #(
         .NHold (NHold),
         .INIT  (INIT)
      ) u_chan (
         .i_clk      (i_clk),
         .i_rst      (i_rst),
         .req        (req_in[g]),
         .out_sig    (out_sig[g]),
         .busy       (busy[g]),
         .idle_nxt_c (idle_nxt_c[g])
      );
   end

   // Built from next-state terms so it updates on the same edge as busy.
   always_ff @(posedge i_clk) begin
      if (i_rst) all_idle <= 1'b1;
      else       all_idle <= &idle_nxt_c;
   end

endmodule
